// File: rtl/serial_deserializer.sv
// serial_deserializer
//   Serial-in, parallel-out receiver. Assembles accepted serial bits into
//   w-bit words (MSB-first or LSB-first, chosen per word) and holds each
//   completed word in a one-entry buffer released by a valid/ready handshake.
//
// Ports
//   clk        in   clock, all state on rising edge
//   rst        in   synchronous active-high reset
//   en         in   bit-sampling enable (handshake ignores it)
//   sin        in   serial data bit
//   sin_valid  in   sin carries a bit this cycle
//   msb_first  in   bit order for the next word (latched on its first bit)
//   clear      in   abort partial word, clear overflow
//   o          out  held word
//   o_valid    out  o holds an unconsumed word
//   o_ready    in   consumer takes o this cycle
//   overflow   out  sticky: a completed word was dropped
//   busy       out  partial word in progress
//   bit_count  out  bits accepted in the current word
module serial_deserializer #(
  parameter int w = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 sin,
  input  logic                 sin_valid,
  input  logic                 msb_first,
  input  logic                 clear,
  output logic [w-1:0]         o,
  output logic                 o_valid,
  input  logic                 o_ready,
  output logic                 overflow,
  output logic                 busy,
  output logic [$clog2(w)-1:0] bit_count
);

  localparam int CW = $clog2(w);

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  state_t        state_q;
  logic [w-1:0]  sr_q;
  logic          order_q;

  logic          accept;
  logic          order_eff;
  logic          last;
  logic          xfer;
  logic [w-1:0]  shifted;

  assign accept    = en && sin_valid && !clear;
  // The order input only matters for the first bit of a word; after that
  // the latched copy governs so mid-word changes are ignored.
  assign order_eff = (state_q == IDLE) ? msb_first : order_q;
  assign shifted   = order_eff ? {sr_q[w-2:0], sin} : {sin, sr_q[w-1:1]};
  assign last      = accept && (bit_count == CW'(w - 1));
  assign xfer      = o_valid && o_ready;
  assign busy      = (state_q == SHIFT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      sr_q      <= '0;
      order_q   <= 1'b1;
      bit_count <= '0;
      o         <= '0;
      o_valid   <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      // Default handshake: a transfer empties the buffer; a completion
      // below may refill it on the same edge.
      if (xfer) o_valid <= 1'b0;

      if (clear) begin
        state_q   <= IDLE;
        sr_q      <= '0;
        bit_count <= '0;
        overflow  <= 1'b0;
      end else if (accept) begin
        if (state_q == IDLE) order_q <= msb_first;
        if (last) begin
          state_q   <= IDLE;
          sr_q      <= '0;
          bit_count <= '0;
          if (!o_valid || xfer) begin
            o       <= shifted;
            o_valid <= 1'b1;
          end else begin
            overflow <= 1'b1;
          end
        end else begin
          state_q   <= SHIFT;
          sr_q      <= shifted;
          bit_count <= bit_count + 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/serial_deserializer.md
# serial_deserializer

Serial-in, parallel-out receiver for the ALU datapath. It assembles a bit stream into `w`-bit words, MSB-first or LSB-first, and holds each completed word in a one-entry output buffer. The buffer is released through a valid/ready handshake. The block feeds serially transferred operands into the parallel register file.

## Interface
- `w`, default 8: word width; also the number of bits per word.

- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `en`  in  1  global enable for bit sampling; the output handshake is unaffected by `en`.
- `sin`  in  1  serial data bit.
- `sin_valid`  in  1  `sin` carries a bit this cycle.
- `msb_first`  in  1  bit order: 1 = MSB first, 0 = LSB first.
- `clear`  in  1  abort the partial word and clear `overflow`.
- `o`  out  w  assembled word (holding register).
- `o_valid`  out  1  `o` holds an unconsumed word.
- `o_ready`  in  1  consumer accepts `o` this cycle.
- `overflow`  out  1  sticky: a completed word was dropped.
- `busy`  out  1  partial word in progress (`bit_count` != 0).
- `bit_count`  out  $clog2(w)  bits accepted in the current word.

## Operation
- Bit accept condition: `en && sin_valid && !clear`.
- States:
  - IDLE (`bit_count`=0).
  - SHIFT (0<`bit_count`<w).
- Transitions:
  - IDLE→SHIFT on the first accepted bit.
  - SHIFT→IDLE on the w-th accepted bit, or on `clear`.
- `msb_first` is latched when the first bit of a word is accepted and applies to the whole word. Changes mid-word are ignored.
- Shift rule, with partial register `sr`:
  - MSB-first: `sr <= {sr[w-2:0], sin}`.
  - LSB-first: `sr <= {sin, sr[w-1:1]}`.
- Word completion happens when the w-th bit is accepted. The completed word is `sr` with that final bit included. At completion `bit_count` returns to 0.
- Handshake:
  - A transfer occurs when `o_valid && o_ready`.
  - `o` is stable while `o_valid`=1.
  - `o_valid` clears after a transfer unless a new word completes on the same edge.
- Load rules at completion:
  - If `o_valid`=0, or a transfer occurs the same cycle: `o` <= completed word and `o_valid` <= 1.
  - Otherwise the word is dropped, `o` and `o_valid` are unchanged, and `overflow` <= 1.
- `clear`:
  - Zeroes `sr` and `bit_count` and clears `overflow`. A bit presented that cycle is discarded.
  - Does not touch `o` or `o_valid`. The handshake proceeds normally that cycle.
- `en`=0 freezes `sr`, `bit_count` and the latched order. `o_ready` can still consume `o`.
- Reset (highest priority):
  - `o`=0, `o_valid`=0, `overflow`=0, `bit_count`=0, `busy`=0.
  - `sr`=0, latched order = MSB-first.
  - Reset mid-word discards the partial word and any held word.

## Timing
- One bit per cycle maximum, with no gap required between words.
- Latency: `o_valid` rises on the same edge that samples the w-th bit. Data is visible in the cycle after that edge.
- A word can be consumed in the cycle `o_valid` is first seen, giving sustained throughput of 1 word per w cycles.
- `overflow` sets on the edge of the dropped completion. It clears only on `rst` or `clear`.
- `busy` and `bit_count` are registered and reflect bits accepted up to the last edge.
- No combinational path from `sin` to `o`. `o_ready` affects only the next state.

## Test plan
- Reset: hold `rst`=1 for 2 cycles with `sin_valid`=1 → `o`=0, `o_valid`=0, `overflow`=0, `bit_count`=0.
- Bit order: send 1,1,0,1,0,0,0,0 with `o_ready`=1.
  - `msb_first`=1 → `o`=8'hD0.
  - `msb_first`=0 → `o`=8'h0B.
  - In both cases `o_valid` rises after the 8th edge.
- Overflow: `o_ready`=0, send 8'h12 then 8'h34.
  - `o` stays 8'h12 and `overflow`=1 after the 16th edge.
  - Then pulse `o_ready` for 1 cycle → `o_valid`=0, `overflow` still 1.
  - Then `clear` → `overflow`=0.
- Back-to-back: `o_ready`=1 held high, send 16 consecutive bits forming 8'hD0 then 8'h0F → `o_valid` is a 1-cycle pulse after edges 8 and 16, `o` shows 8'hD0 then 8'h0F, `overflow`=0.
- Clear mid-word: send 3 bits, assert `clear` with `sin_valid`=1, then send 8'h5A → `bit_count`=0 after the clear edge and `o`=8'h5A, uncorrupted.
- Stall and order latch:
  - Send 4 bits of 8'hA5 MSB-first, drop `en` for 3 cycles and flip `msb_first`, then send the remaining 4 bits → `o`=8'hA5.
  - Assert `rst` mid-word in a repeat run → no `o_valid`, `o`=0.
